// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit bitwise logic unit (AND/OR/XOR/AND-NOT)
// among NUM_REQ valid/ready requesters, returning results through one registered slot.
module logic_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [2*NUM_REQ-1:0]  req_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [ID_W-1:0]       resp_id,
  output logic [15:0]           resp_count
);
  localparam int DATA_W = 32;
  localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ-1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic [15:0]         count_q, count_d;

  logic                slot_free;
  logic                grant_any;
  logic [ID_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]  grant_vec;
  logic [ID_W:0]       scan_sum;
  logic [ID_W-1:0]     scan_idx;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic [1:0]          sel_op;

  function automatic logic [DATA_W-1:0] logic_op(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [1:0]        op);
    logic [DATA_W-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = a & ~b;
    endcase
    return r;
  endfunction

  // The slot can take a new result when it is empty or being drained this cycle.
  assign slot_free = (state_q == EMPTY) | resp_ready;

  // Round-robin scan starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (reset_n && slot_free) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (scan_sum >= NUM_REQ_X) begin
          scan_sum = scan_sum - NUM_REQ_X;
        end
        scan_idx = scan_sum[ID_W-1:0];
        if (!grant_any && req_valid[scan_idx]) begin
          grant_any           = 1'b1;
          grant_idx           = scan_idx;
          grant_vec[scan_idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant_vec;

  // One-hot operand mux driven by the grant vector.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vec[i]) begin
        sel_a  = sel_a  | req_a[i*DATA_W +: DATA_W];
        sel_b  = sel_b  | req_b[i*DATA_W +: DATA_W];
        sel_op = sel_op | req_op[i*2 +: 2];
      end
    end
  end

  // Next state: response slot occupancy, pointer, payload and handshake counter.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    count_d     = count_q;
    case (state_q)
      EMPTY: begin
        if (grant_any) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (resp_ready) begin
          count_d = count_q + 16'd1;
          if (!grant_any) begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    if (grant_any) begin
      resp_data_d = logic_op(sel_a, sel_b, sel_op);
      resp_id_d   = grant_idx;
      ptr_d       = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      ptr_q       <= '0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      count_q     <= count_d;
    end
  end

  assign resp_valid = (state_q == FULL);
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_count = count_q;

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one 32-bit bitwise logic unit (AND / OR / XOR / AND-NOT) among NUM_REQ requesters using round-robin arbitration. Each requester uses a valid/ready handshake. The result comes back through a single registered response port with backpressure and carries the granted requester's ID. The block sits between the processor's functional-unit issue logic and the shared 32-bit bitwise datapath. It serialises logic operations at up to one per cycle.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, response ID width; must equal ceil(log2(NUM_REQ))

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  bit i = requester i has an operation pending
- req_ready  out  NUM_REQ  bit i = requester i granted this cycle; at most one bit high
- req_a  in  32*NUM_REQ  operand A; requester i on bits [32i+31:32i]
- req_b  in  32*NUM_REQ  operand B; same packing
- req_op  in  2*NUM_REQ  opcode; requester i on bits [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 A & ~B
- resp_valid  out  1  response register holds a result
- resp_ready  in  1  consumer accepts the response this cycle
- resp_data  out  32  result
- resp_id  out  ID_W  index of the requester that produced resp_data
- resp_count  out  16  number of completed response handshakes, wraps 0xFFFF -> 0x0000

## Operation
- There are two states, from resp_valid: EMPTY (0) and FULL (1).
- slot_free = !resp_valid | resp_ready.
- Grant:
  - When slot_free = 1, scan req_valid starting at pointer ptr, ascending and wrapping modulo NUM_REQ.
  - The first set bit i is granted: req_ready[i] = 1.
  - req_ready is combinational from req_valid, ptr, resp_valid and resp_ready.
- Accept: req_valid[i] & req_ready[i] at an edge. On that edge:
  - resp_data <= op(req_a_i, req_b_i, req_op_i)
  - resp_id <= i
  - resp_valid <= 1
  - ptr <= (i+1) mod NUM_REQ
- No grant: ptr is unchanged.
- State transitions:
  - EMPTY with grant -> FULL.
  - EMPTY with no request -> EMPTY.
  - FULL with resp_ready and a grant -> FULL; a new result replaces the old one on the same edge.
  - FULL with resp_ready and no grant -> EMPTY; resp_valid <= 0, resp_data/resp_id hold their last values.
  - FULL with !resp_ready -> FULL; all req_ready = 0; resp_data/resp_id stable.
- Response handshake: resp_valid & resp_ready. Each one increments resp_count by 1.
- Requester rules: once req_valid[i] rises, requester i holds it, req_a, req_b and req_op stable until accepted. req_valid must not depend on req_ready.
- Deasserting req_valid before acceptance is illegal. The bench flags it; RTL behaviour is undefined.
- Reset (reset_n = 0, asynchronous, including mid-operation):
  - resp_valid = 0, resp_data = 0, resp_id = 0, resp_count = 0, ptr = 0.
  - req_ready forced to all 0 while reset_n = 0.
  - Any pending response is discarded.

## Timing
- Latency: accept at edge t -> resp_valid = 1 and result visible after edge t, i.e. one cycle.
- Throughput: one operation per cycle while resp_ready = 1 and any req_valid is set.
- Backpressure: resp_ready = 0 while FULL blocks all grants in that same cycle, with no lost or duplicated results.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.
- resp_count updates on the edge of the response handshake and is visible the next cycle.
- First grant is possible in the first cycle after reset_n deasserts.

## Test plan
- Single op:
  - Stimulus: requester 2 only, A = 0xF0F0_1234, B = 0x0FF0_FFFF, op 00.
  - Response: req_ready = 0100 in the same cycle; next cycle resp_valid = 1, resp_data = 0x00F0_1234, resp_id = 2; resp_count goes 0 -> 1 after resp_ready.
- All opcodes:
  - Stimulus: A = 0xAAAA_5555, B = 0xFFFF_0000 on requester 0, ops 00/01/10/11.
  - Response: 0xAAAA_0000, 0xFFFF_5555, 0x5555_5555, 0x0000_5555.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously, resp_ready = 1.
  - Response: resp_id sequence 0,1,2,3,0,1; one result per cycle.
- Backpressure:
  - Stimulus: requesters 1 and 3 valid, resp_ready = 0 for 3 cycles.
  - Response: req_ready = 0000 while FULL; resp_id = 1 with data held stable; on release, id 1 is consumed and id 3 is granted on the same edge.
- Reset mid-operation:
  - Stimulus: pull reset_n low asynchronously while FULL with resp_count = 5.
  - Response: outputs go to 0 immediately; after release ptr = 0, so requester 0 wins when 0 and 2 request together.
- resp_count wrap:
  - Stimulus: 65,536 responses.
  - Response: resp_count returns to 0x0000.
